// File: rtl/tlb_inv_engine.sv
// INVTLB walker: sweeps every TLB compare entry once, clearing the E bit of
// entries that match the latched op/ASID/VA. Invalid op codes raise a one-cycle INE pulse.
module tlb_inv_engine #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = $clog2(TLBNUM)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [9:0]            req_asid,
  input  logic [31:0]           req_va,
  output logic [TLBNUMSIZE-1:0] rd_idx,
  input  logic [36:0]           rd_ci,
  input  logic                  hold,
  output logic                  clr_en,
  output logic [TLBNUMSIZE-1:0] clr_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  ine
);

  typedef enum logic [1:0] {IDLE, WALK, DONE, ERR} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } inv_req_t;

  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
  } ci_t;

  state_t                state;
  logic [TLBNUMSIZE-1:0] cnt;
  inv_req_t              req_q;
  ci_t                   ci;
  logic                  last;
  logic                  asid_hit;
  logic                  va_hit;
  logic                  hit;
  logic                  unused_va;

  assign unused_va = ^req_va[12:0];
  assign ci        = rd_ci;
  assign last      = (cnt == TLBNUMSIZE'(TLBNUM - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ine       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q     <= '{op: req_op, asid: req_asid, vpn: req_va[31:13]};
          cnt       <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (req_op > 5'd6) begin
            state <= ERR;
            ine   <= 1'b1;
          end else begin
            state <= WALK;
          end
        end
        // A held cycle re-reads the same entry next cycle; the last entry ends the walk without wrapping.
        WALK: if (!hold) begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + TLBNUMSIZE'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        ERR: begin
          state     <= IDLE;
          ine       <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 2 MB pages (PS=21) compare only the upper VPPN bits.
  assign va_hit   = (ci.ps == 6'd21) ? (ci.vppn[18:9] == req_q.vpn[18:9])
                                     : (ci.vppn == req_q.vpn);
  assign asid_hit = (ci.asid == req_q.asid);

  always_comb begin
    hit = 1'b0;
    case (req_q.op)
      5'd0, 5'd1: hit = 1'b1;
      5'd2:       hit = ci.e && ci.g;
      5'd3:       hit = ci.e && !ci.g;
      5'd4:       hit = ci.e && !ci.g && asid_hit;
      5'd5:       hit = ci.e && !ci.g && asid_hit && va_hit;
      5'd6:       hit = ci.e && (ci.g || asid_hit) && va_hit;
      default:    hit = 1'b0;
    endcase
  end

  // Gated by reset so an aborting walk never clears the entry under the reset edge.
  assign clr_en  = aresetn && (state == WALK) && hit && !hold;
  assign rd_idx  = cnt;
  assign clr_idx = cnt;

endmodule

// File: tb/tb_tlb_inv_engine.sv
// Bench for tlb_inv_engine: driver pushes expected clear/done/ine events with
// their cycle numbers; a negedge monitor pops and compares what the DUT emits.
module tb_tlb_inv_engine;
  localparam int N = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        hold = 1'b0;
  logic [4:0]  req_op = '0;
  logic [9:0]  req_asid = '0;
  logic [31:0] req_va = '0;
  logic        req_ready, clr_en, busy, done, ine;
  logic [3:0]  rd_idx, clr_idx;
  logic [36:0] rd_ci;
  logic [36:0] tlb [N];

  tlb_inv_engine #(.TLBNUM(N)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_asid(req_asid), .req_va(req_va), .rd_idx(rd_idx),
    .rd_ci(rd_ci), .hold(hold), .clr_en(clr_en), .clr_idx(clr_idx),
    .busy(busy), .done(done), .ine(ine)
  );

  assign rd_ci = tlb[rd_idx];
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef enum {EV_CLR, EV_DONE, EV_INE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       cyc;
  } ev_t;
  ev_t sb[$];

  bit chk_on = 0, exp_ready = 1, chk_idx = 0, finish_req = 0;
  int exp_idx = 0;
  int tests = 0, fails = 0;

  function automatic bit ref_match(input logic [4:0] op, input logic [9:0] asid,
                                   input logic [18:0] va, input logic [36:0] e);
    bit v, g, aeq, vam;
    logic [5:0] ps;
    logic [18:0] vppn;
    v    = e[36];
    aeq  = (e[35:26] == asid);
    g    = e[25];
    ps   = e[24:19];
    vppn = e[18:0];
    vam  = (ps == 6'd21) ? (vppn[18:9] == va[18:9]) : (vppn == va);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return v && g;
      5'd3:       return v && !g;
      5'd4:       return v && !g && aeq;
      5'd5:       return v && !g && aeq && vam;
      5'd6:       return v && (g || aeq) && vam;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic chk_ev(input ev_kind_t k, input int idx);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event cyc=%0d: got %s idx=%0d, none expected", cyc, k.name(), idx);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.idx != idx || e.cyc != cyc) begin
        fails++;
        $display("FAIL event: got %s idx=%0d cyc=%0d, want %s idx=%0d cyc=%0d",
                 k.name(), idx, cyc, e.kind.name(), e.idx, e.cyc);
      end
    end
  endtask

  always @(negedge aclk) begin
    if (chk_on) begin
      tests++;
      if (req_ready !== exp_ready || busy !== !exp_ready) begin
        fails++;
        $display("FAIL ready_busy cyc=%0d: ready=%b busy=%b, want ready=%b busy=%b",
                 cyc, req_ready, busy, exp_ready, !exp_ready);
      end
      if (chk_idx) begin
        tests++;
        if (int'(rd_idx) != exp_idx || int'(clr_idx) != exp_idx) begin
          fails++;
          $display("FAIL index cyc=%0d: rd_idx=%0d clr_idx=%0d, want %0d", cyc, rd_idx, clr_idx, exp_idx);
        end
      end
    end
    if (clr_en === 1'b1) chk_ev(EV_CLR, int'(clr_idx));
    if (done === 1'b1)   chk_ev(EV_DONE, 0);
    if (ine === 1'b1)    chk_ev(EV_INE, 0);
    if (finish_req) begin
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL missing_events: %0d left, first %s idx=%0d cyc=%0d",
                 sb.size(), sb[0].kind.name(), sb[0].idx, sb[0].cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_ev(input ev_kind_t k, input int idx, input int c);
    ev_t e;
    e.kind = k; e.idx = idx; e.cyc = c;
    sb.push_back(e);
  endtask

  // Starts in the cycle where the engine is expected idle; returns at the first idle cycle after.
  task automatic run_op(input logic [4:0] op, input logic [9:0] asid, input logic [31:0] va, input int mode);
    int a, d, idx, j, nh;
    bit h;
    bit hp[64];
    int ix[64];
    logic [18:0] v;
    v = va[31:13];
    a = cyc;
    d = a + 1;
    for (int k = 0; k < 64; k++) begin hp[k] = 0; ix[k] = 0; end
    if (op > 5'd6) begin
      push_ev(EV_INE, 0, a + 1);
    end else begin
      idx = 0; nh = 0; j = 1;
      while (1) begin
        case (mode)
          1:       h = ($urandom_range(0, 3) == 0) && (j < 40);
          2:       h = (idx == 4) && (nh < 3);
          default: h = 0;
        endcase
        if (h) nh++;
        hp[j] = h;
        ix[j] = idx;
        if (!h) begin
          if (ref_match(op, asid, v, tlb[idx])) push_ev(EV_CLR, idx, a + j);
          if (idx == N - 1) begin
            d = a + j + 1;
            break;
          end
          idx++;
        end
        j++;
      end
      push_ev(EV_DONE, 0, d);
    end
    req_valid = 1; req_op = op; req_asid = asid; req_va = va;
    hold = 1'($urandom); exp_ready = 1; chk_idx = 0;
    step();
    for (int k = 1; k <= d - a; k++) begin
      // Junk requests while busy must be ignored.
      req_valid = 1'($urandom); req_op = 5'($urandom); req_asid = 10'($urandom); req_va = $urandom;
      hold      = (op <= 5'd6 && k < d - a) ? hp[k] : 1'($urandom);
      exp_ready = 0;
      chk_idx   = (op <= 5'd6 && k < d - a);
      exp_idx   = ix[k];
      step();
    end
    req_valid = 0; hold = 0; exp_ready = 1; chk_idx = 0;
  endtask

  task automatic run_reset_mid_walk();
    int a;
    for (int i = 0; i < N; i++) tlb[i] = {1'b1, 36'($urandom)};
    a = cyc;
    req_valid = 1; req_op = 5'd0; req_asid = '0; req_va = '0;
    hold = 0; exp_ready = 1; chk_idx = 0;
    step();
    for (int k = 1; k <= 9; k++) begin
      req_valid = 0; exp_ready = 0; chk_idx = 1; exp_idx = k - 1;
      if (k <= 8) push_ev(EV_CLR, k - 1, a + k);
      if (k == 9) aresetn = 0;
      step();
    end
    aresetn = 1; exp_ready = 1; chk_idx = 1; exp_idx = 0;
    repeat (4) step();
    chk_idx = 0;
  endtask

  function automatic logic [36:0] rand_entry();
    logic [9:0]  a;
    logic [18:0] vp;
    a  = $urandom_range(0, 1) ? 10'h012 : 10'h013;
    vp = 19'($urandom) & 19'h00603;
    return {1'($urandom_range(0, 3) != 0), a, 1'($urandom), ($urandom_range(0, 1) ? 6'd21 : 6'd12), vp};
  endfunction

  initial begin
    logic [4:0]  op;
    logic [31:0] va;
    int r;
    for (int i = 0; i < N; i++) tlb[i] = '0;
    aresetn = 0;
    @(posedge aclk); #1;
    chk_on = 1; exp_ready = 1; chk_idx = 1; exp_idx = 0;
    step(); step();
    aresetn = 1;
    step();
    chk_idx = 0;

    // op 0 over a fully valid TLB
    for (int i = 0; i < N; i++) tlb[i] = {1'b1, 36'($urandom)};
    run_op(5'd0, 10'h000, 32'h0, 0);

    // op 5: ASID + 4 KB page match, neighbour with other ASID survives
    for (int i = 0; i < N; i++) tlb[i] = '0;
    tlb[3] = {1'b1, 10'h012, 1'b0, 6'd12, 19'h00201};
    tlb[7] = {1'b1, 10'h013, 1'b0, 6'd12, 19'h00201};
    run_op(5'd5, 10'h012, 32'h00402000, 0);

    // op 6: global 2 MB page
    for (int i = 0; i < N; i++) tlb[i] = '0;
    tlb[9] = {1'b1, 10'h000, 1'b1, 6'd21, 19'h00400};
    run_op(5'd6, 10'h155, 32'h00800000, 0);

    // op 2 with a 3-cycle hold parked on entry 4
    for (int i = 0; i < N; i++) tlb[i] = {1'b1, 10'($urandom), 1'b0, 6'd12, 19'($urandom)};
    tlb[4][25] = 1'b1;
    run_op(5'd2, 10'h000, 32'h0, 2);

    run_op(5'd7, 10'h000, 32'h0, 0);
    step();
    run_reset_mid_walk();

    repeat (40) begin
      for (int i = 0; i < N; i++) tlb[i] = rand_entry();
      r  = $urandom_range(0, 9);
      op = (r <= 7) ? 5'(r) : 5'($urandom_range(8, 31));
      va = {19'($urandom) & 19'h00603, 13'($urandom)};
      run_op(op, $urandom_range(0, 1) ? 10'h012 : 10'h013, va, $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
    end

    finish_req = 1;
    @(negedge aclk);
    #20;
    $display("FAIL finish: monitor did not end the run");
    $fatal(1);
  end

endmodule
